// File: rtl/ocp_pkg.sv
// ocp_pkg: shared OCP-style request/response encodings and host serial
// protocol byte constants used by the UART bridge and its slaves.
package ocp_pkg;

  // Master command encodings carried on MCmd
  localparam logic [2:0] MCMD_IDLE = 3'b000;
  localparam logic [2:0] MCMD_WR   = 3'b001;
  localparam logic [2:0] MCMD_RD   = 3'b010;

  // Slave response encodings carried on SResp
  localparam logic [1:0] SRESP_NULL = 2'b00;
  localparam logic [1:0] SRESP_DVA  = 2'b01;
  localparam logic [1:0] SRESP_FAIL = 2'b10;
  localparam logic [1:0] SRESP_ERR  = 2'b11;

  // Host serial protocol bytes
  localparam logic [7:0] BYTE_WR  = 8'h57;  // 'W' write opcode
  localparam logic [7:0] BYTE_RD  = 8'h52;  // 'R' read opcode
  localparam logic [7:0] BYTE_ACK = 8'h06;  // success
  localparam logic [7:0] BYTE_NAK = 8'h15;  // slave error or frame timeout
  localparam logic [7:0] BYTE_BAD = 8'h3F;  // '?' unknown opcode

endpackage

// File: rtl/uart_ocp_bridge_frame_timer.sv
// frame_timer: inter-byte idle counter for a partially received frame.
// Only instantiated when UART_OCP_BRIDGE_TIMEOUT_EN is defined.
module frame_timer #(
  parameter logic [15:0] P_RX_TIMEOUT = 16'd5000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  input  logic rx_valid,
  output logic expired
);

  logic [15:0] count;

  // Count idle clocks while a frame is open; any received byte or leaving the frame restarts at zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= 16'd0;
    end else if (!run || rx_valid) begin
      count <= 16'd0;
    end else begin
      count <= count + 16'd1;
    end
  end

  assign expired = run && (count == (P_RX_TIMEOUT - 16'd1));

endmodule

// File: rtl/uart_ocp_bridge.sv
// uart_ocp_bridge: turns host UART frames ('W' addr data / 'R' addr) into
// single OCP-style requests and returns the slave response as UART bytes.
// Optional feature macro: UART_OCP_BRIDGE_TIMEOUT_EN discards a partial
// frame after P_RX_TIMEOUT idle clocks and answers with 0x15.
module uart_ocp_bridge
  import ocp_pkg::*;
#(
  parameter logic [15:0] P_RX_TIMEOUT = 16'd5000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_valid,
  input  logic [7:0] rx_data,
  output logic       tx_valid,
  output logic [7:0] tx_data,
  input  logic       tx_ready,
  output logic [2:0] MCmd,
  output logic [7:0] MAddr,
  output logic [7:0] MData,
  input  logic       SCmdAccept,
  input  logic [1:0] SResp,
  input  logic [7:0] SData,
  output logic [2:0] bridge_state,
  output logic       rx_overrun
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_GET_ADDR  = 3'd1;
  localparam logic [2:0] S_GET_DATA  = 3'd2;
  localparam logic [2:0] S_REQ       = 3'd3;
  localparam logic [2:0] S_WAIT_RESP = 3'd4;
  localparam logic [2:0] S_SEND      = 3'd5;

  logic [2:0] state;
  logic [2:0] op;
  logic [1:0] resp_q;
  logic [7:0] sdata_q;
  logic       second_sent;
  logic       rx_timeout;
  logic       frame_open;

  assign frame_open   = (state == S_GET_ADDR) || (state == S_GET_DATA);
  assign bridge_state = state;

`ifdef UART_OCP_BRIDGE_TIMEOUT_EN
  frame_timer #(
    .P_RX_TIMEOUT(P_RX_TIMEOUT)
  ) u_frame_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .run     (frame_open),
    .rx_valid(rx_valid),
    .expired (rx_timeout)
  );
`else
  // Without the timeout a partial frame waits forever; the parameter only
  // feeds a sink so both builds share one parameter list.
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^P_RX_TIMEOUT ^ frame_open;
  assign rx_timeout = 1'b0;
`endif

  // Main protocol FSM: frame assembly, request issue, response capture and byte return
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      op          <= MCMD_IDLE;
      MCmd        <= MCMD_IDLE;
      MAddr       <= 8'h00;
      MData       <= 8'h00;
      tx_valid    <= 1'b0;
      tx_data     <= 8'h00;
      resp_q      <= SRESP_NULL;
      sdata_q     <= 8'h00;
      second_sent <= 1'b0;
      rx_overrun  <= 1'b0;
    end else begin
      if (rx_valid && (state == S_REQ || state == S_WAIT_RESP || state == S_SEND)) begin
        rx_overrun <= 1'b1;
      end
      case (state)
        S_IDLE: begin
          if (rx_valid) begin
            if (rx_data == BYTE_WR) begin
              op    <= MCMD_WR;
              state <= S_GET_ADDR;
            end else if (rx_data == BYTE_RD) begin
              op    <= MCMD_RD;
              state <= S_GET_ADDR;
            end else begin
              resp_q      <= SRESP_NULL;
              tx_valid    <= 1'b1;
              tx_data     <= BYTE_BAD;
              second_sent <= 1'b0;
              state       <= S_SEND;
            end
          end
        end
        S_GET_ADDR: begin
          if (rx_valid) begin
            MAddr <= rx_data;
            if (op == MCMD_WR) begin
              state <= S_GET_DATA;
            end else begin
              MCmd  <= op;
              state <= S_REQ;
            end
          end else if (rx_timeout) begin
            resp_q      <= SRESP_NULL;
            tx_valid    <= 1'b1;
            tx_data     <= BYTE_NAK;
            second_sent <= 1'b0;
            state       <= S_SEND;
          end
        end
        S_GET_DATA: begin
          if (rx_valid) begin
            MData <= rx_data;
            MCmd  <= op;
            state <= S_REQ;
          end else if (rx_timeout) begin
            resp_q      <= SRESP_NULL;
            tx_valid    <= 1'b1;
            tx_data     <= BYTE_NAK;
            second_sent <= 1'b0;
            state       <= S_SEND;
          end
        end
        S_REQ: begin
          if (SCmdAccept) begin
            MCmd  <= MCMD_IDLE;
            state <= S_WAIT_RESP;
          end
        end
        S_WAIT_RESP: begin
          if (SResp != SRESP_NULL) begin
            resp_q      <= SResp;
            sdata_q     <= SData;
            tx_valid    <= 1'b1;
            tx_data     <= (SResp == SRESP_DVA) ? BYTE_ACK : BYTE_NAK;
            second_sent <= 1'b0;
            state       <= S_SEND;
          end
        end
        S_SEND: begin
          if (tx_valid && tx_ready) begin
            if (!second_sent && resp_q == SRESP_DVA && op == MCMD_RD) begin
              tx_data     <= sdata_q;
              second_sent <= 1'b1;
            end else begin
              tx_valid <= 1'b0;
              state    <= S_IDLE;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_ocp_bridge.sv
// tb_uart_ocp_bridge: directed self-checking bench for uart_ocp_bridge.
// Honours UART_OCP_BRIDGE_TIMEOUT_EN for the partial-frame scenario.
module tb_uart_ocp_bridge;

  logic       clk;
  logic       rst_n;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready;
  logic [2:0] MCmd;
  logic [7:0] MAddr;
  logic [7:0] MData;
  logic       SCmdAccept;
  logic [1:0] SResp;
  logic [7:0] SData;
  logic [2:0] bridge_state;
  logic       rx_overrun;

  int assertCount = 0;
  int failCount   = 0;
  logic sawCmd;

  uart_ocp_bridge #(
    .P_RX_TIMEOUT(16'd8)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rx_valid    (rx_valid),
    .rx_data     (rx_data),
    .tx_valid    (tx_valid),
    .tx_data     (tx_data),
    .tx_ready    (tx_ready),
    .MCmd        (MCmd),
    .MAddr       (MAddr),
    .MData       (MData),
    .SCmdAccept  (SCmdAccept),
    .SResp       (SResp),
    .SData       (SData),
    .bridge_state(bridge_state),
    .rx_overrun  (rx_overrun)
  );

  // 100 MHz bench clock; the design only cares about edges
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance to just after the next rising edge so drives and samples sit clear of it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one received byte for exactly one clock
  task automatic applyStimulus(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    tick();
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  // Count one comparison and report it if it does not match
  task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed %h, expected %h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Every output at its reset value
  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_mcmd"},   16'(MCmd),         16'h0);
    checkOutput({tag, "_maddr"},  16'(MAddr),        16'h0);
    checkOutput({tag, "_mdata"},  16'(MData),        16'h0);
    checkOutput({tag, "_txv"},    16'(tx_valid),     16'h0);
    checkOutput({tag, "_txd"},    16'(tx_data),      16'h0);
    checkOutput({tag, "_state"},  16'(bridge_state), 16'h0);
    checkOutput({tag, "_ovr"},    16'(rx_overrun),   16'h0);
  endtask

  initial begin
    rst_n      = 1'b0;
    rx_valid   = 1'b0;
    rx_data    = 8'h00;
    tx_ready   = 1'b1;
    SCmdAccept = 1'b0;
    SResp      = 2'b00;
    SData      = 8'h00;
    sawCmd     = 1'b0;

    #2;
    checkResetValues("rst");
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Write 57 12 A5, slave accepts at once and answers two clocks later
    $display("[TB] write frame");
    SCmdAccept = 1'b1;
    applyStimulus(8'h57);
    checkOutput("wr_state_addr", 16'(bridge_state), 16'h1);
    applyStimulus(8'h12);
    checkOutput("wr_state_data", 16'(bridge_state), 16'h2);
    applyStimulus(8'hA5);
    checkOutput("wr_mcmd",  16'(MCmd),         16'h1);
    checkOutput("wr_maddr", 16'(MAddr),        16'h12);
    checkOutput("wr_mdata", 16'(MData),        16'hA5);
    checkOutput("wr_state_req", 16'(bridge_state), 16'h3);
    tick();
    checkOutput("wr_mcmd_drop", 16'(MCmd), 16'h0);
    checkOutput("wr_state_wait", 16'(bridge_state), 16'h4);
    tick();
    SCmdAccept = 1'b0;
    SResp = 2'b01;
    checkOutput("wr_txv_early", 16'(tx_valid), 16'h0);
    tick();
    SResp = 2'b00;
    checkOutput("wr_txv",   16'(tx_valid), 16'h1);
    checkOutput("wr_txd",   16'(tx_data),  16'h06);
    checkOutput("wr_state_send", 16'(bridge_state), 16'h5);
    tick();
    checkOutput("wr_txv_done", 16'(tx_valid), 16'h0);
    checkOutput("wr_state_idle", 16'(bridge_state), 16'h0);

    // Read 52 80 with request and transmit backpressure
    $display("[TB] read frame with backpressure");
    tx_ready = 1'b0;
    applyStimulus(8'h52);
    applyStimulus(8'h80);
    checkOutput("rd_maddr", 16'(MAddr), 16'h80);
    for (int i = 0; i < 4; i++) begin
      checkOutput("rd_mcmd_hold", 16'(MCmd), 16'h2);
      if (i == 3) SCmdAccept = 1'b1;
      tick();
    end
    SCmdAccept = 1'b0;
    checkOutput("rd_mcmd_drop", 16'(MCmd), 16'h0);
    checkOutput("rd_state_wait", 16'(bridge_state), 16'h4);
    SResp = 2'b01;
    SData = 8'h3C;
    tick();
    SResp = 2'b00;
    SData = 8'h00;
    for (int i = 0; i < 5; i++) begin
      checkOutput("rd_ack_txv_hold", 16'(tx_valid), 16'h1);
      checkOutput("rd_ack_txd_hold", 16'(tx_data),  16'h06);
      tick();
    end
    tx_ready = 1'b1;
    tick();
    tx_ready = 1'b0;
    checkOutput("rd_data_txv", 16'(tx_valid), 16'h1);
    checkOutput("rd_data_txd", 16'(tx_data),  16'h3C);
    tick();
    checkOutput("rd_data_txd_hold", 16'(tx_data), 16'h3C);
    tx_ready = 1'b1;
    tick();
    checkOutput("rd_txv_done", 16'(tx_valid), 16'h0);
    checkOutput("rd_state_idle", 16'(bridge_state), 16'h0);

    // Read of 0x90 answered with ERR gives a single 0x15
    $display("[TB] error response and bad opcode");
    SCmdAccept = 1'b1;
    applyStimulus(8'h52);
    applyStimulus(8'h90);
    checkOutput("err_mcmd",  16'(MCmd),  16'h2);
    checkOutput("err_maddr", 16'(MAddr), 16'h90);
    tick();
    SCmdAccept = 1'b0;
    SResp = 2'b11;
    SData = 8'h77;
    tick();
    SResp = 2'b00;
    SData = 8'h00;
    checkOutput("err_txv", 16'(tx_valid), 16'h1);
    checkOutput("err_txd", 16'(tx_data),  16'h15);
    tick();
    checkOutput("err_single_txv", 16'(tx_valid), 16'h0);
    checkOutput("err_state_idle", 16'(bridge_state), 16'h0);

    applyStimulus(8'h41);
    checkOutput("bad_txv",   16'(tx_valid),     16'h1);
    checkOutput("bad_txd",   16'(tx_data),      16'h3F);
    checkOutput("bad_mcmd",  16'(MCmd),         16'h0);
    checkOutput("bad_state", 16'(bridge_state), 16'h5);
    tick();
    checkOutput("bad_txv_done", 16'(tx_valid), 16'h0);
    checkOutput("bad_mcmd_after", 16'(MCmd), 16'h0);

    // Partial frame 57 12 followed by silence
    $display("[TB] partial frame");
    sawCmd = 1'b0;
    applyStimulus(8'h57);
    applyStimulus(8'h12);
`ifdef UART_OCP_BRIDGE_TIMEOUT_EN
    for (int i = 0; i < 7; i++) begin
      tick();
      if (MCmd != 3'b000) sawCmd = 1'b1;
    end
    checkOutput("to_state_before", 16'(bridge_state), 16'h2);
    checkOutput("to_txv_before",   16'(tx_valid),     16'h0);
    tick();
    checkOutput("to_txv", 16'(tx_valid), 16'h1);
    checkOutput("to_txd", 16'(tx_data),  16'h15);
    tick();
    checkOutput("to_state_idle", 16'(bridge_state), 16'h0);
`else
    for (int i = 0; i < 20; i++) begin
      tick();
      if (MCmd != 3'b000) sawCmd = 1'b1;
    end
    checkOutput("nto_state", 16'(bridge_state), 16'h2);
    checkOutput("nto_txv",   16'(tx_valid),     16'h0);
`endif
    checkOutput("to_no_mcmd", 16'(sawCmd), 16'h0);
    rst_n = 1'b0;
    #1;
    checkOutput("to_reset_state", 16'(bridge_state), 16'h0);
    tick();
    rst_n = 1'b1;
    tick();

    // Extra byte 55 while waiting for the response
    $display("[TB] overrun");
    checkOutput("ovr_pre", 16'(rx_overrun), 16'h0);
    SCmdAccept = 1'b1;
    applyStimulus(8'h57);
    applyStimulus(8'h22);
    applyStimulus(8'h33);
    checkOutput("ovr_mcmd", 16'(MCmd), 16'h1);
    tick();
    SCmdAccept = 1'b0;
    applyStimulus(8'h55);
    checkOutput("ovr_flag",  16'(rx_overrun),   16'h1);
    checkOutput("ovr_state", 16'(bridge_state), 16'h4);
    checkOutput("ovr_maddr", 16'(MAddr),        16'h22);
    checkOutput("ovr_mdata", 16'(MData),        16'h33);
    SResp = 2'b01;
    SData = 8'h99;
    tick();
    SResp = 2'b00;
    SData = 8'h00;
    checkOutput("ovr_txv", 16'(tx_valid), 16'h1);
    checkOutput("ovr_txd", 16'(tx_data),  16'h06);
    tick();
    checkOutput("ovr_txv_done", 16'(tx_valid), 16'h0);
    checkOutput("ovr_state_idle", 16'(bridge_state), 16'h0);
    checkOutput("ovr_sticky", 16'(rx_overrun), 16'h1);

    // Reset while waiting for a read response, then a clean read
    $display("[TB] reset mid-operation");
    SCmdAccept = 1'b1;
    applyStimulus(8'h52);
    applyStimulus(8'h44);
    tick();
    SCmdAccept = 1'b0;
    checkOutput("mid_state_wait", 16'(bridge_state), 16'h4);
    rst_n = 1'b0;
    #1;
    checkResetValues("mid_rst");
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    applyStimulus(8'h52);
    applyStimulus(8'h00);
    checkOutput("post_mcmd",  16'(MCmd),  16'h2);
    checkOutput("post_maddr", 16'(MAddr), 16'h00);
    SCmdAccept = 1'b1;
    tick();
    SCmdAccept = 1'b0;
    checkOutput("post_mcmd_drop", 16'(MCmd), 16'h0);
    SResp = 2'b01;
    SData = 8'h5A;
    tick();
    SResp = 2'b00;
    SData = 8'h00;
    checkOutput("post_ack", 16'(tx_data), 16'h06);
    tick();
    checkOutput("post_data_txv", 16'(tx_valid), 16'h1);
    checkOutput("post_data_txd", 16'(tx_data),  16'h5A);
    tick();
    checkOutput("post_txv_done", 16'(tx_valid), 16'h0);
    checkOutput("post_state_idle", 16'(bridge_state), 16'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/uart_ocp_bridge.md
# uart_ocp_bridge

- Converts the UART receive byte stream into single OCP-style requests (MCmd/MAddr/MData) and returns the slave response as UART transmit bytes.
- Sits between the UART byte receiver/transmitter and the `tree_link` UART master port.
- Provides the only request source for the line buffer and debugger address map.
- Owns all framing and error reporting for the host serial protocol.

## Interface
Parameters:
- P_RX_TIMEOUT, 16'd5000, idle clocks allowed between bytes of one frame (used only with the timeout feature).

Ports:
- clk  in  1  50MHz system clock.
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low.
- rx_valid  in  1  one-cycle strobe, received byte available.
- rx_data  in  8  received byte.
- tx_valid  out  1  byte to transmit is presented.
- tx_data  out  8  byte to transmit.
- tx_ready  in  1  transmitter takes the byte on a clock where tx_valid&tx_ready.
- MCmd  out  3  000 idle, 001 WR, 010 RD.
- MAddr  out  8  request address.
- MData  out  8  write data.
- SCmdAccept  in  1  request accepted on a clock where MCmd!=0.
- SResp  in  2  00 NULL, 01 DVA, 10 FAIL, 11 ERR; one-cycle pulse.
- SData  in  8  read data, valid with SResp.
- bridge_state  out  3  current FSM state (debug).
- rx_overrun  out  1  sticky: a byte was dropped.

## Operation
- Frame formats:
  - write = 'W'(0x57), addr, data.
  - read = 'R'(0x52), addr.
- FSM states:
  - IDLE=0
  - GET_ADDR=1
  - GET_DATA=2
  - REQ=3
  - WAIT_RESP=4
  - SEND=5
- IDLE:
  - rx 0x57 → GET_ADDR, op=WR.
  - rx 0x52 → GET_ADDR, op=RD.
  - Any other byte → SEND with single byte 0x3F ('?').
- GET_ADDR: rx byte → latch MAddr. Then GET_DATA if WR, REQ if RD.
- GET_DATA: rx byte → latch MData, → REQ.
- REQ:
  - MCmd = op, with MAddr/MData stable.
  - On a clock with SCmdAccept=1 → WAIT_RESP, and MCmd returns to 000 in the next cycle.
- WAIT_RESP:
  - Slave must not drive SResp in the accept cycle.
  - On a clock with SResp!=00, latch SResp/SData → SEND.
- Response bytes:
  - WR DVA → 0x06.
  - RD DVA → 0x06 then SData.
  - FAIL/ERR → 0x15 only.
- SEND:
  - Each byte is held on tx_data with tx_valid=1 until tx_valid&tx_ready.
  - After the last byte → IDLE.
- Dropped bytes: rx_valid in REQ, WAIT_RESP or SEND drops the byte and sets rx_overrun. rx_overrun clears only on reset.
- MData is don't-care for RD; it holds its last value.

## Timing
- Reset values:
  - MCmd=000, MAddr=00, MData=00.
  - tx_valid=0, tx_data=00.
  - bridge_state=0, rx_overrun=0.
  - Internal latched response cleared to 00.
- Reset mid-operation:
  - The FSM returns to IDLE immediately and outputs take their reset values.
  - A partially sent response is lost.
- All outputs are registered, with no combinational input-to-output path.
- The rx byte completing a frame at cycle N gives MCmd!=0 at cycle N+1.
- SCmdAccept=1 at cycle M gives MCmd=000 at M+1.
- SResp pulse at cycle K gives tx_valid=1 at K+1.
- Against `tree_link` (accepts in the first request cycle, responds 2 clocks later), the last rx byte to tx_valid is 4 clocks.
- Multi-byte response: the second byte is presented in the cycle after the first handshake.

## Configuration
- Macro UART_OCP_BRIDGE_TIMEOUT_EN. Defined:
  - A 16-bit counter runs in GET_ADDR/GET_DATA and reloads to 0 on each rx_valid.
  - When the count reaches P_RX_TIMEOUT-1 with no byte, the frame is discarded and the FSM enters SEND with single byte 0x15, without issuing MCmd.
  - The counter is held at 0 in all other states.
- Undefined: there is no counter and a partial frame waits indefinitely.

## Structure
- Shared package ocp_pkg holds:
  - MCmd encodings (IDLE/WR/RD).
  - SResp encodings (NULL/DVA/FAIL/ERR).
  - Protocol byte constants (0x57, 0x52, 0x06, 0x15, 0x3F).
- FSM state encodings stay local to the block.
- One sub-module: frame_timer, the inter-byte timeout counter. It is instantiated only under UART_OCP_BRIDGE_TIMEOUT_EN.

## Test plan
- Write: rx 57,12,A5 with slave accepting immediately and SResp=01 two clocks later → MCmd=001, MAddr=12, MData=A5 for exactly one cycle; tx 06.
- Read with backpressure:
  - rx 52,80; slave holds SCmdAccept=0 for 3 cycles, then SResp=01 with SData=3C.
  - Required: MCmd=010 held for 4 cycles; tx 06 then 3C.
  - Required: with tx_ready low 5 cycles, each byte is held stable until accepted.
- Error and bad opcode: SResp=11 on read of 0x90 → tx single 15. rx byte 41 in IDLE → tx 3F, and no MCmd.
- Overrun: extra rx byte 55 during WAIT_RESP → dropped, rx_overrun=1 until reset, and the response is unchanged.
- Timeout (macro on, P_RX_TIMEOUT=8): rx 57,12 then silence → tx 15 after 8 idle clocks, MCmd never asserted. Macro off → the FSM stays in GET_DATA.
- Reset asserted during WAIT_RESP → all outputs at reset values in the same cycle; after release, the next frame 52,00 completes normally.
